dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, word-address width of data memory (128 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter MEM_LAT, default 1, cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-004 Port clk  in  1  single clock; all state updates on posedge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports core_req/core_we  in  1 each  pipeline MEM-stage request and write flag.
REQ-007 Ports core_addr  in  ADDR_W; core_wdata  in  DATA_W  core access address and store data.
REQ-008 Ports core_rdata  out  DATA_W; core_ack  out  1  core load data and completion pulse.
REQ-009 Port core_stall  out  1  freeze the pipeline while a core request is pending.
REQ-010 Ports ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack: loader/debug requester, widths as core_*.
REQ-011 Ports mem_en, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  single-port memory drive.
REQ-012 Port mem_rdata  in  DATA_W  memory read data.
REQ-013 Port busy  out  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS, WAIT and RESP.
REQ-015 IDLE: if any req is high, pick an owner, latch its we/addr/wdata and go to ACCESS; otherwise stay.
REQ-016 ACCESS: mem_en=1 and mem_we/addr/wdata = latched fields for exactly one cycle; load lat_cnt=MEM_LAT-1; go to WAIT.
REQ-017 WAIT: hold mem_en=0; decrement lat_cnt; when lat_cnt==0, register mem_rdata (0 for writes) and go to RESP.
REQ-018 RESP: pulse the owner's ack for one cycle with rdata valid; go to IDLE.
REQ-019 With req sampled in cycle t, mem_en SHALL be high in t+1 and ack SHALL be high in t+2+MEM_LAT.
REQ-020 The requester holds req and fields stable until ack; the arbiter uses latched fields only, so a mid-transaction req drop SHALL NOT abort it and ack still pulses.
REQ-021 req is not sampled in ACCESS, WAIT or RESP; a req held high through ack is treated as a new request in the following IDLE cycle.
REQ-022 The non-owner ack SHALL stay 0; rdata outputs SHALL hold their last value between acks.
REQ-023 core_stall = core_req & ~core_ack (combinational), including while the loader owns the memory.
REQ-024 mem_* outputs SHALL be registered; mem_we/addr/wdata SHALL be 0 whenever mem_en=0.

Reset
REQ-025 rst SHALL force IDLE, all outputs 0, lat_cnt 0, last_owner=LOADER immediately and asynchronously.
REQ-026 rst asserted mid-transaction SHALL abort it with no ack; the aborted requester must re-request.

Configuration
REQ-027 With DMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not served last (last_owner updated in ACCESS).
REQ-028 Without DMEM_ARB_RR_EN, core SHALL always win simultaneous requests; last_owner logic SHALL be absent; loader starvation is permitted.

Structure
REQ-029 Package dmem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/WAIT/RESP), the owner enum (CORE/LOADER) and default ADDR_W/DATA_W constants.
REQ-030 Owner selection SHALL be one sub-module, dmem_arb_pick (inputs core_req, ldr_req, last_owner; output owner), combinational.

Verification
REQ-031 Core load addr 13, mem[13]=0x0000_00AB, MEM_LAT=1 -> mem_en in t+1, core_ack and core_rdata=0xAB in t+3, core_stall high t..t+2.
REQ-032 Loader write addr 5 data 0xDEAD_BEEF, then core load addr 5 -> core_rdata=0xDEAD_BEEF; ldr_rdata=0 on the write ack.
REQ-033 Both req high in the same cycle after reset -> core served first; both held -> with RR_EN loader next, without RR_EN core again.
REQ-034 MEM_LAT=4, core read -> ack exactly at t+6; core drops req in WAIT -> ack still pulses, one access only.
REQ-035 rst pulsed in WAIT -> busy=0, no ack, mem_en=0; re-issued request completes normally.
REQ-036 Core req held high continuously -> one transaction per 3+MEM_LAT cycles, one mem_en per transaction, never two acks without an intervening IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Round-robin arbitration is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        CORE,
        LOADER
    } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational owner selection between the core and the loader.
// With DMEM_ARB_RR_EN defined, ties go to whoever was not served last; otherwise the core always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   core_req,
    input  logic   ldr_req,
`ifdef DMEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output owner_t owner
);

    always_comb begin
        owner = CORE;
`ifdef DMEM_ARB_RR_EN
        if (core_req && ldr_req) begin
            owner = (last_owner == CORE) ? LOADER : CORE;
        end else if (ldr_req) begin
            owner = LOADER;
        end
`else
        if (ldr_req && !core_req) begin
            owner = LOADER;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory with fixed read latency MEM_LAT.
// Define DMEM_ARB_RR_EN to switch tie-breaking from core-priority to round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_stall,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    owner_t                 r_owner;
    owner_t                 w_pick_owner;
    logic                   r_we;
    logic [LAT_CNT_W-1:0]   r_lat_cnt;

    logic                   r_mem_en;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;

    logic [DATA_W-1:0]      r_core_rdata;
    logic [DATA_W-1:0]      r_ldr_rdata;
    logic                   r_core_ack;
    logic                   r_ldr_ack;

    logic                   w_any_req;
    logic                   w_lat_done;
    logic                   w_sel_we;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic [DATA_W-1:0]      w_resp_data;

`ifdef DMEM_ARB_RR_EN
    owner_t                 r_last_owner;

    dmem_arb_pick u_pick (
        .core_req   (core_req),
        .ldr_req    (ldr_req),
        .last_owner (r_last_owner),
        .owner      (w_pick_owner)
    );
`else
    dmem_arb_pick u_pick (
        .core_req   (core_req),
        .ldr_req    (ldr_req),
        .owner      (w_pick_owner)
    );
`endif

    assign w_any_req   = core_req | ldr_req;
    assign w_lat_done  = (r_lat_cnt == '0);
    assign w_sel_we    = (w_pick_owner == CORE) ? core_we    : ldr_we;
    assign w_sel_addr  = (w_pick_owner == CORE) ? core_addr  : ldr_addr;
    assign w_sel_wdata = (w_pick_owner == CORE) ? core_wdata : ldr_wdata;
    assign w_resp_data = r_we ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ACCESS;
            ACCESS:  w_next_state = WAIT;
            WAIT:    if (w_lat_done) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The mem_* registers carry the latched request for the single ACCESS cycle and are zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= CORE;
            r_we         <= 1'b0;
            r_lat_cnt    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_rdata <= '0;
            r_ldr_rdata  <= '0;
            r_core_ack   <= 1'b0;
            r_ldr_ack    <= 1'b0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_core_ack  <= 1'b0;
            r_ldr_ack   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_pick_owner;
                        r_we        <= w_sel_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                ACCESS: begin
                    r_lat_cnt <= LAT_INIT;
                end
                WAIT: begin
                    if (!w_lat_done) begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end else if (r_owner == CORE) begin
                        r_core_rdata <= w_resp_data;
                        r_core_ack   <= 1'b1;
                    end else begin
                        r_ldr_rdata  <= w_resp_data;
                        r_ldr_ack    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Recorded at ACCESS so a transaction killed by reset before then does not shift priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= LOADER;
        end else if (r_state == ACCESS) begin
            r_last_owner <= r_owner;
        end
    end
`endif

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_rdata = r_core_rdata;
    assign ldr_rdata  = r_ldr_rdata;
    assign core_ack   = r_core_ack;
    assign ldr_ack    = r_ldr_ack;
    assign busy       = (r_state != IDLE);
    assign core_stall = core_req & ~r_core_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=4.
// Expected arbitration order follows DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;

    logic        c_req, c_we, l_req, l_we;
    logic [6:0]  c_addr, l_addr, m_addr;
    logic [31:0] c_wdata, l_wdata, c_rdata, l_rdata, m_wdata, m_rdata;
    logic        c_ack, c_stall, l_ack, m_en, m_we, busy;

    logic        c4_req, c4_we, l4_req, l4_we;
    logic [6:0]  c4_addr, l4_addr, m4_addr;
    logic [31:0] c4_wdata, l4_wdata, c4_rdata, l4_rdata, m4_wdata, m4_rdata;
    logic        c4_ack, c4_stall, l4_ack, m4_en, m4_we, busy4;

    logic [31:0] mem1 [128];
    logic [31:0] mem4 [128];
    logic [31:0] pipe1;
    logic [31:0] pipe4 [4];
    int          en1Count;
    int          en4Count;

    int          passes;
    int          checks;

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .core_req(c_req), .core_we(c_we), .core_addr(c_addr), .core_wdata(c_wdata),
        .core_rdata(c_rdata), .core_ack(c_ack), .core_stall(c_stall),
        .ldr_req(l_req), .ldr_we(l_we), .ldr_addr(l_addr), .ldr_wdata(l_wdata),
        .ldr_rdata(l_rdata), .ldr_ack(l_ack),
        .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MEM_LAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .core_req(c4_req), .core_we(c4_we), .core_addr(c4_addr), .core_wdata(c4_wdata),
        .core_rdata(c4_rdata), .core_ack(c4_ack), .core_stall(c4_stall),
        .ldr_req(l4_req), .ldr_we(l4_we), .ldr_addr(l4_addr), .ldr_wdata(l4_wdata),
        .ldr_rdata(l4_rdata), .ldr_ack(l4_ack),
        .mem_en(m4_en), .mem_we(m4_we), .mem_addr(m4_addr), .mem_wdata(m4_wdata),
        .mem_rdata(m4_rdata), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data appears MEM_LAT cycles after mem_en, junk otherwise.
    always @(posedge clk) begin
        if (m_en && m_we) mem1[m_addr] <= m_wdata;
        pipe1 <= (m_en && !m_we) ? mem1[m_addr] : 32'hBAD0_0001;
    end
    assign m_rdata = pipe1;

    always @(posedge clk) begin
        if (m4_en && m4_we) mem4[m4_addr] <= m4_wdata;
        pipe4[0] <= (m4_en && !m4_we) ? mem4[m4_addr] : 32'hBAD0_0004;
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
    end
    assign m4_rdata = pipe4[3];

    always @(negedge clk) begin
        if (m_en)  en1Count <= en1Count + 1;
        if (m4_en) en4Count <= en4Count + 1;
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)  $display("FAIL reset_busy got %0b want 0", busy);   else passes++;
        checks++; if (m_en !== 1'b0)  $display("FAIL reset_mem_en got %0b want 0", m_en); else passes++;
        checks++; if (c_ack !== 1'b0 || l_ack !== 1'b0)
            $display("FAIL reset_acks got %0b/%0b want 0/0", c_ack, l_ack); else passes++;
        checks++; if (c_rdata !== 32'h0 || m_addr !== 7'h0)
            $display("FAIL reset_data got rdata %h addr %h want 0/0", c_rdata, m_addr); else passes++;
        checks++; if (busy4 !== 1'b0 || m4_en !== 1'b0)
            $display("FAIL reset_dut4 got busy %0b en %0b want 0/0", busy4, m4_en); else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL idle_no_req got busy %0b want 0", busy); else passes++;
    endtask

    task automatic test_core_load();
        c_req = 1'b1; c_we = 1'b0; c_addr = 7'd13; c_wdata = 32'h0;
        #1;
        checks++; if (c_stall !== 1'b1) $display("FAIL load_stall_t got %0b want 1", c_stall); else passes++;
        @(negedge clk);
        checks++; if (m_en !== 1'b1 || m_addr !== 7'd13 || m_we !== 1'b0)
            $display("FAIL load_access got en %0b addr %0d we %0b want 1/13/0", m_en, m_addr, m_we); else passes++;
        checks++; if (c_stall !== 1'b1) $display("FAIL load_stall_t1 got %0b want 1", c_stall); else passes++;
        @(negedge clk);
        checks++; if (m_en !== 1'b0 || m_addr !== 7'd0 || c_ack !== 1'b0)
            $display("FAIL load_wait got en %0b addr %0d ack %0b want 0/0/0", m_en, m_addr, c_ack); else passes++;
        checks++; if (c_stall !== 1'b1 || busy !== 1'b1)
            $display("FAIL load_stall_t2 got stall %0b busy %0b want 1/1", c_stall, busy); else passes++;
        @(negedge clk);
        checks++; if (c_ack !== 1'b1 || c_rdata !== 32'h0000_00AB)
            $display("FAIL load_ack got ack %0b rdata %h want 1/000000ab", c_ack, c_rdata); else passes++;
        checks++; if (c_stall !== 1'b0 || l_ack !== 1'b0)
            $display("FAIL load_ack_side got stall %0b lack %0b want 0/0", c_stall, l_ack); else passes++;
        c_req = 1'b0;
        @(negedge clk);
        checks++; if (c_ack !== 1'b0 || c_rdata !== 32'h0000_00AB || busy !== 1'b0)
            $display("FAIL load_hold got ack %0b rdata %h busy %0b want 0/000000ab/0", c_ack, c_rdata, busy); else passes++;
    endtask

    task automatic test_loader_then_core();
        int n;
        logic wrWe;
        logic [31:0] wrData;
        l_req = 1'b1; l_we = 1'b0; l_addr = 7'd13; l_wdata = 32'h0;
        n = 0;
        do begin @(negedge clk); n++; end while (!l_ack && n < 12);
        checks++; if (l_ack !== 1'b1 || n != 3 || l_rdata !== 32'h0000_00AB)
            $display("FAIL ldr_read got ack %0b cyc %0d rdata %h want 1/3/000000ab", l_ack, n, l_rdata); else passes++;
        l_req = 1'b0;
        @(negedge clk);
        l_req = 1'b1; l_we = 1'b1; l_addr = 7'd5; l_wdata = 32'hDEAD_BEEF;
        n = 0; wrWe = 1'b0; wrData = 32'h0;
        do begin
            @(negedge clk); n++;
            if (n == 1) begin wrWe = m_we; wrData = m_wdata; end
        end while (!l_ack && n < 12);
        checks++; if (wrWe !== 1'b1 || wrData !== 32'hDEAD_BEEF)
            $display("FAIL ldr_write_drive got we %0b data %h want 1/deadbeef", wrWe, wrData); else passes++;
        checks++; if (l_ack !== 1'b1 || l_rdata !== 32'h0 || c_ack !== 1'b0)
            $display("FAIL ldr_write_ack got ack %0b rdata %h cack %0b want 1/0/0", l_ack, l_rdata, c_ack); else passes++;
        checks++; if (mem1[5] !== 32'hDEAD_BEEF)
            $display("FAIL ldr_write_mem got %h want deadbeef", mem1[5]); else passes++;
        l_req = 1'b0; l_we = 1'b0;
        @(negedge clk);
        c_req = 1'b1; c_we = 1'b0; c_addr = 7'd5;
        n = 0;
        do begin @(negedge clk); n++; end while (!c_ack && n < 12);
        checks++; if (c_ack !== 1'b1 || c_rdata !== 32'hDEAD_BEEF || l_ack !== 1'b0)
            $display("FAIL core_after_write got ack %0b rdata %h lack %0b want 1/deadbeef/0", c_ack, c_rdata, l_ack); else passes++;
        c_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        logic [6:0] expAddr2;
        logic       expC, expL, expStall;
`ifdef DMEM_ARB_RR_EN
        expAddr2 = 7'd5;  expC = 1'b0; expL = 1'b1; expStall = 1'b1;
`else
        expAddr2 = 7'd13; expC = 1'b1; expL = 1'b0; expStall = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 7'd13;
        l_req = 1'b1; l_we = 1'b0; l_addr = 7'd5;
        @(negedge clk);
        checks++; if (m_addr !== 7'd13) $display("FAIL tie_first got addr %0d want 13", m_addr); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (c_ack !== 1'b1 || l_ack !== 1'b0 || c_rdata !== 32'h0000_00AB)
            $display("FAIL tie_first_ack got %0b/%0b rdata %h want 1/0/000000ab", c_ack, l_ack, c_rdata); else passes++;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL tie_idle got busy %0b want 0", busy); else passes++;
        @(negedge clk);
        checks++; if (m_en !== 1'b1 || m_addr !== expAddr2 || c_stall !== 1'b1)
            $display("FAIL tie_second got en %0b addr %0d stall %0b want 1/%0d/1", m_en, m_addr, c_stall, expAddr2); else passes++;
        repeat (2) @(negedge clk);
        checks++; if (c_ack !== expC || l_ack !== expL || c_stall !== expStall)
            $display("FAIL tie_second_ack got %0b/%0b stall %0b want %0b/%0b/%0b", c_ack, l_ack, c_stall, expC, expL, expStall); else passes++;
`ifdef DMEM_ARB_RR_EN
        checks++; if (l_rdata !== 32'hDEAD_BEEF) $display("FAIL tie_ldr_data got %h want deadbeef", l_rdata); else passes++;
`endif
        c_req = 1'b0; l_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency4();
        int first, acks, lacks, enBefore;
        enBefore = en4Count;
        c4_req = 1'b1; c4_we = 1'b0; c4_addr = 7'd20;
        first = 0; acks = 0; lacks = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (l4_ack) lacks++;
            if (c4_ack) begin
                acks++;
                if (first == 0) first = i;
                c4_req = 1'b0;
            end
        end
        checks++; if (first != 6 || acks != 1)
            $display("FAIL lat4_ack got cycle %0d count %0d want 6/1", first, acks); else passes++;
        checks++; if (c4_rdata !== 32'h1234_5678 || en4Count - enBefore != 1)
            $display("FAIL lat4_data got %h en %0d want 12345678/1", c4_rdata, en4Count - enBefore); else passes++;
        enBefore = en4Count;
        c4_req = 1'b1; c4_addr = 7'd21;
        first = 0; acks = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++; if (c4_stall !== 1'b1) $display("FAIL lat4_stall got %0b want 1", c4_stall); else passes++;
            end
            if (i == 2) c4_req = 1'b0;
            if (l4_ack) lacks++;
            if (c4_ack) begin
                acks++;
                if (first == 0) first = i;
            end
        end
        checks++; if (first != 6 || acks != 1 || en4Count - enBefore != 1)
            $display("FAIL lat4_drop got cycle %0d acks %0d en %0d want 6/1/1", first, acks, en4Count - enBefore); else passes++;
        checks++; if (c4_rdata !== 32'h5A5A_0021 || lacks != 0 || l4_rdata !== 32'h0)
            $display("FAIL lat4_drop_data got %h lacks %0d lrdata %h want 5a5a0021/0/0", c4_rdata, lacks, l4_rdata); else passes++;
    endtask

    task automatic test_reset_abort();
        int acks, n;
        c_req = 1'b1; c_we = 1'b0; c_addr = 7'd13;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL abort_pre got busy %0b want 1", busy); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || m_en !== 1'b0 || c_ack !== 1'b0 || c_rdata !== 32'h0)
            $display("FAIL abort_async got busy %0b en %0b ack %0b rdata %h want 0/0/0/0", busy, m_en, c_ack, c_rdata); else passes++;
        c_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (c_ack || m_en || busy) acks++;
        end
        checks++; if (acks != 0) $display("FAIL abort_quiet got %0d active cycles want 0", acks); else passes++;
        c_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!c_ack && n < 12);
        checks++; if (c_ack !== 1'b1 || n != 3 || c_rdata !== 32'h0000_00AB)
            $display("FAIL abort_retry got ack %0b cyc %0d rdata %h want 1/3/000000ab", c_ack, n, c_rdata); else passes++;
        c_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acks, first, last, idles, doubles, enBefore;
        logic prevAck;
        enBefore = en1Count;
        acks = 0; first = 0; last = 0; idles = 0; doubles = 0; prevAck = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 7'd13;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (c_ack) begin
                acks++;
                if (first == 0) first = i;
                last = i;
                if (prevAck) doubles++;
            end
            if (!busy) idles++;
            prevAck = c_ack;
        end
        c_req = 1'b0;
        @(negedge clk);
        checks++; if (acks != 4 || first != 3 || last != 15)
            $display("FAIL b2b_acks got %0d first %0d last %0d want 4/3/15", acks, first, last); else passes++;
        checks++; if (idles != 4 || doubles != 0 || en1Count - enBefore != 4)
            $display("FAIL b2b_spacing got idles %0d doubles %0d en %0d want 4/0/4", idles, doubles, en1Count - enBefore); else passes++;
    endtask

    initial begin
        passes = 0; checks = 0;
        en1Count = 0; en4Count = 0;
        for (int i = 0; i < 128; i++) begin
            mem1[i] = 32'h0;
            mem4[i] = 32'h0;
        end
        mem1[13] = 32'h0000_00AB;
        mem4[20] = 32'h1234_5678;
        mem4[21] = 32'h5A5A_0021;
        rst = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
        c4_req = 1'b0; c4_we = 1'b0; c4_addr = '0; c4_wdata = '0;
        l4_req = 1'b0; l4_we = 1'b0; l4_addr = '0; l4_wdata = '0;

        test_reset();
        test_core_load();
        test_loader_then_core();
        test_simultaneous();
        test_latency4();
        test_reset_abort();
        test_back_to_back();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
